// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end.
// Holds the fetch PC, issues word-aligned requests to the instruction cache,
// and presents one registered instruction per cycle to the decoder.
// Two states: FETCH (normal operation) and DROP (the response of a squashed
// in-flight request is discarded before the redirect target is fetched).
// Optional feature: define FETCH_JAL_PREDECODE_EN to follow JAL targets at
// capture time instead of falling through to pc+4.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

`ifndef OPCODE_JUMP
`define OPCODE_JUMP 7'b1101111
`endif

module fetch_stage #(
    parameter int unsigned          INSTR_SIZE = `WORD_SIZE,
    parameter logic [`WORD_SIZE-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   icache_req,
    output logic [`WORD_SIZE-1:0]  icache_addr,
    input  logic                   icache_ready,
    input  logic [INSTR_SIZE-1:0]  icache_data,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [`WORD_SIZE-1:0]  redirect_pc,
    output logic [INSTR_SIZE-1:0]  instr_out,
    output logic [`WORD_SIZE-1:0]  pc_out,
    output logic                   valid_out
);

    localparam int unsigned W = `WORD_SIZE;

    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } state_t;

    state_t         state;
    logic [W-1:0]   pc;
    logic [W-1:0]   pending_pc;

    logic           blocked;
    logic           outstanding;
    logic [W-1:0]   redirect_aligned;
    logic [W-1:0]   seq_pc;
    logic [W-1:0]   next_pc;
    logic           unused_redirect_low;

    // Decoder holding a live instruction freezes fetch; the request is
    // suppressed only then, so a miss once issued is never withdrawn.
    assign blocked          = (state == FETCH) && stall && valid_out;
    assign icache_req       = !reset && !blocked;
    assign icache_addr      = pc;
    assign outstanding      = icache_req && !icache_ready;
    assign redirect_aligned = {redirect_pc[W-1:2], 2'b00};
    assign seq_pc           = pc + W'(4);
    assign unused_redirect_low = ^redirect_pc[1:0];

`ifdef FETCH_JAL_PREDECODE_EN
    logic [31:0]    word;
    logic [W-1:0]   jal_imm;
    logic [W-1:0]   jal_sum;
    logic           is_jal;
    logic           unused_word_bits;

    // Sign-extended J-type immediate of the word being captured.
    always_comb begin
        word    = 32'(icache_data);
        is_jal  = (word[6:0] == `OPCODE_JUMP);
        jal_imm = W'($signed({word[31], word[19:12], word[20], word[30:21], 1'b0}));
        jal_sum = pc + jal_imm;
        next_pc = is_jal ? {jal_sum[W-1:2], 2'b00} : seq_pc;
    end

    assign unused_word_bits = ^word[11:7];
`else
    assign next_pc = seq_pc;
`endif

    // Fetch FSM with registered decoder-side outputs; redirect has top priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            pending_pc <= '0;
            valid_out  <= 1'b0;
            instr_out  <= '0;
            pc_out     <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        valid_out <= 1'b0;
                        // A request still waiting on the cache keeps its
                        // address; the target waits in pending_pc.
                        if (outstanding) begin
                            pending_pc <= redirect_aligned;
                            state      <= DROP;
                        end else begin
                            pc <= redirect_aligned;
                        end
                    end else if (blocked) begin
                        valid_out <= valid_out;
                    end else if (icache_ready) begin
                        instr_out <= icache_data;
                        pc_out    <= pc;
                        valid_out <= 1'b1;
                        pc        <= next_pc;
                    end else begin
                        valid_out <= 1'b0;
                    end
                end
                DROP: begin
                    valid_out <= 1'b0;
                    if (redirect) begin
                        pending_pc <= redirect_aligned;
                    end else if (icache_ready) begin
                        pc    <= pending_pc;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage.
// Directed scenarios followed by randomized traffic compared against a
// transaction-level reference model of the fetch rules.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready = 1'b0;
    logic [31:0] icache_data = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: where fetch goes next, what the decoder holds, and
    // whether the next cache response belongs to a squashed request.
    logic [31:0] m_pc, m_target, m_instr, m_pcout;
    logic        m_valid, m_discard;

    fetch_stage #(.INSTR_SIZE(32), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .icache_req   (icache_req),
        .icache_addr  (icache_addr),
        .icache_ready (icache_ready),
        .icache_data  (icache_data),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .valid_out    (valid_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic exp_req();
        // The decoder holding a live word is the only thing that stops requests.
        return !reset && !(!m_discard && stall && m_valid);
    endfunction

    function automatic logic [31:0] exp_next_seq(input logic [31:0] pc, input logic [31:0] w);
        logic [31:0] off;
        off = 32'd4;
`ifdef FETCH_JAL_PREDECODE_EN
        if (w[6:0] == 7'h6f) begin
            off = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
        end
`endif
        return (pc + off) & 32'hffff_fffc;
    endfunction

    task automatic setin(input logic r, input logic st, input logic rd,
                         input logic [31:0] rpc, input logic rdy, input logic [31:0] d);
        @(negedge clk);
        reset        = r;
        stall        = st;
        redirect     = rd;
        redirect_pc  = rpc;
        icache_ready = rdy;
        icache_data  = d;
        #1;
    endtask

    task automatic tick();
        logic req, accepted;
        req      = exp_req();
        accepted = req && icache_ready;
        if (reset) begin
            m_pc = 32'h0; m_target = 32'h0; m_discard = 1'b0;
            m_valid = 1'b0; m_instr = 32'h0; m_pcout = 32'h0;
        end else if (m_discard) begin
            if (redirect) m_target = redirect_pc & 32'hffff_fffc;
            else if (accepted) begin
                m_pc = m_target;
                m_discard = 1'b0;
            end
        end else if (redirect) begin
            m_valid = 1'b0;
            if (req && !icache_ready) begin
                m_target  = redirect_pc & 32'hffff_fffc;
                m_discard = 1'b1;
            end else begin
                m_pc = redirect_pc & 32'hffff_fffc;
            end
        end else if (accepted) begin
            m_instr = icache_data;
            m_pcout = m_pc;
            m_valid = 1'b1;
            m_pc    = exp_next_seq(m_pc, icache_data);
        end else if (req) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        setin(1, 0, 0, 32'h0, 1, $urandom);
        n_cmp++; if (icache_req !== 1'b0) begin n_err++; $display("FAIL reset_req0: got %b expected 0", icache_req); end
        tick();
        setin(1, 1, 1, 32'h40, 1, $urandom);
        n_cmp++; if (icache_req !== 1'b0) begin n_err++; $display("FAIL reset_req1: got %b expected 0", icache_req); end
        tick();
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
        n_cmp++; if (instr_out !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h expected 0", instr_out); end
        n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL reset_pcout: got %h expected 0", pc_out); end
        setin(0, 0, 0, 32'h0, 0, 32'h0);
        n_cmp++; if (icache_req !== 1'b1 || icache_addr !== 32'h0)
            begin n_err++; $display("FAIL reset_addr: got req=%b addr=%h expected req=1 addr=0", icache_req, icache_addr); end
        tick();
    endtask

    task automatic test_hits();
        setin(0, 0, 0, 32'h0, 1, 32'h003100b3);
        n_cmp++; if (icache_addr !== 32'h0) begin n_err++; $display("FAIL hit0_addr: got %h expected 0", icache_addr); end
        tick();
        n_cmp++; if (valid_out !== 1'b1 || pc_out !== 32'h0 || instr_out !== 32'h003100b3)
            begin n_err++; $display("FAIL hit0_out: got v=%b pc=%h i=%h expected v=1 pc=0 i=003100b3", valid_out, pc_out, instr_out); end
        setin(0, 0, 0, 32'h0, 1, 32'h00108093);
        n_cmp++; if (icache_addr !== 32'h4) begin n_err++; $display("FAIL hit1_addr: got %h expected 4", icache_addr); end
        tick();
        n_cmp++; if (valid_out !== 1'b1 || pc_out !== 32'h4 || instr_out !== 32'h00108093)
            begin n_err++; $display("FAIL hit1_out: got v=%b pc=%h i=%h expected v=1 pc=4 i=00108093", valid_out, pc_out, instr_out); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            setin(0, 1, 0, 32'h0, 1, $urandom);
            n_cmp++; if (icache_req !== 1'b0 || icache_addr !== 32'h8)
                begin n_err++; $display("FAIL stall_req: got req=%b addr=%h expected req=0 addr=8", icache_req, icache_addr); end
            tick();
            n_cmp++; if (valid_out !== 1'b1 || pc_out !== 32'h4 || instr_out !== 32'h00108093)
                begin n_err++; $display("FAIL stall_hold: got v=%b pc=%h i=%h expected v=1 pc=4 i=00108093", valid_out, pc_out, instr_out); end
        end
    endtask

    task automatic test_miss();
        for (int i = 0; i < 4; i++) begin
            setin(0, 0, 0, 32'h0, 0, $urandom);
            n_cmp++; if (icache_req !== 1'b1 || icache_addr !== 32'h8)
                begin n_err++; $display("FAIL miss_addr: got req=%b addr=%h expected req=1 addr=8", icache_req, icache_addr); end
            tick();
            n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL miss_valid: got %b expected 0", valid_out); end
        end
        setin(0, 0, 0, 32'h0, 1, 32'h00000013);
        tick();
        n_cmp++; if (valid_out !== 1'b1 || pc_out !== 32'h8 || instr_out !== 32'h00000013)
            begin n_err++; $display("FAIL miss_capture: got v=%b pc=%h i=%h expected v=1 pc=8 i=00000013", valid_out, pc_out, instr_out); end
    endtask

    task automatic test_redirect_drop();
        setin(0, 0, 1, 32'h20, 1, 32'hdeadbeef);
        tick();
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL redir_valid: got %b expected 0", valid_out); end
        setin(0, 0, 0, 32'h0, 0, 32'h0);
        n_cmp++; if (icache_addr !== 32'h20) begin n_err++; $display("FAIL redir_addr: got %h expected 20", icache_addr); end
        tick();
        setin(0, 0, 1, 32'h1c, 0, 32'h0);
        tick();
        setin(0, 0, 0, 32'h0, 0, 32'h0);
        n_cmp++; if (icache_req !== 1'b1 || icache_addr !== 32'h20)
            begin n_err++; $display("FAIL drop_hold: got req=%b addr=%h expected req=1 addr=20", icache_req, icache_addr); end
        tick();
        setin(0, 0, 0, 32'h0, 1, 32'hbadc0de3);
        tick();
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL drop_discard: got %b expected 0", valid_out); end
        setin(0, 0, 0, 32'h0, 1, 32'h00000013);
        n_cmp++; if (icache_addr !== 32'h1c) begin n_err++; $display("FAIL drop_target: got %h expected 1c", icache_addr); end
        tick();
        n_cmp++; if (valid_out !== 1'b1 || pc_out !== 32'h1c)
            begin n_err++; $display("FAIL drop_capture: got v=%b pc=%h expected v=1 pc=1c", valid_out, pc_out); end
    endtask

    task automatic test_jal();
        logic [31:0] exp;
`ifdef FETCH_JAL_PREDECODE_EN
        exp = 32'h1c;
`else
        exp = 32'h30;
`endif
        setin(0, 0, 1, 32'h2c, 1, 32'h0);
        tick();
        setin(0, 0, 0, 32'h0, 1, 32'hff1ff0ef);
        tick();
        n_cmp++; if (pc_out !== 32'h2c || instr_out !== 32'hff1ff0ef)
            begin n_err++; $display("FAIL jal_capture: got pc=%h i=%h expected pc=2c i=ff1ff0ef", pc_out, instr_out); end
        setin(0, 0, 0, 32'h0, 0, 32'h0);
        n_cmp++; if (icache_addr !== exp) begin n_err++; $display("FAIL jal_next: got %h expected %h", icache_addr, exp); end
        tick();
    endtask

    task automatic test_redirect_stall();
        setin(0, 0, 0, 32'h0, 1, 32'h00000013);
        tick();
        setin(0, 1, 1, 32'h23, 0, 32'h0);
        tick();
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL rstall_valid: got %b expected 0", valid_out); end
        n_cmp++; if (icache_addr !== 32'h20) begin n_err++; $display("FAIL rstall_addr: got %h expected 20", icache_addr); end
        setin(0, 1, 0, 32'h0, 0, 32'h0);
        n_cmp++; if (icache_req !== 1'b1) begin n_err++; $display("FAIL rstall_req: got %b expected 1", icache_req); end
        tick();
    endtask

    task automatic test_random();
        logic        prev_hold;
        logic [31:0] prev_addr, d;
        prev_hold = 1'b0;
        prev_addr = '0;
        setin(1, 0, 0, 32'h0, 0, 32'h0);
        tick();
        for (int i = 0; i < 3000; i++) begin
            d = $urandom;
            if ($urandom_range(0, 5) == 0) d[6:0] = 7'h6f;
            setin($urandom_range(0, 60) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0, $urandom,
                  $urandom_range(0, 9) < 6, d);
            n_cmp++; if (icache_req !== exp_req() || icache_addr !== m_pc)
                begin n_err++; $display("FAIL rnd_req[%0d]: got req=%b addr=%h expected req=%b addr=%h", i, icache_req, icache_addr, exp_req(), m_pc); end
            if (prev_hold && !reset) begin
                n_cmp++; if (icache_req !== 1'b1 || icache_addr !== prev_addr)
                    begin n_err++; $display("FAIL rnd_stable[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, icache_req, icache_addr, prev_addr); end
            end
            prev_hold = icache_req && !icache_ready;
            prev_addr = icache_addr;
            tick();
            n_cmp++; if (valid_out !== m_valid || pc_out !== m_pcout || instr_out !== m_instr)
                begin n_err++; $display("FAIL rnd_out[%0d]: got v=%b pc=%h i=%h expected v=%b pc=%h i=%h", i, valid_out, pc_out, instr_out, m_valid, m_pcout, m_instr); end
        end
    endtask

    initial begin
        m_pc = '0; m_target = '0; m_instr = '0; m_pcout = '0;
        m_valid = 1'b0; m_discard = 1'b0;
        test_reset();
        test_hits();
        test_stall();
        test_miss();
        test_redirect_drop();
        test_jal();
        test_redirect_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter INSTR_SIZE, default `WORD_SIZE, instruction width delivered to decoder.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 icache_req  out  1  fetch request valid.
REQ-006 icache_addr  out  `WORD_SIZE  word-aligned fetch address.
REQ-007 icache_ready  in  1  icache_data valid for the held request this cycle (hit: same cycle; miss: N cycles later).
REQ-008 icache_data  in  INSTR_SIZE  fetched instruction word.
REQ-009 stall  in  1  decoder cannot accept; hold output register.
REQ-010 redirect  in  1  taken branch/jump from execute; flush and refetch.
REQ-011 redirect_pc  in  `WORD_SIZE  redirect target.
REQ-012 instr_out  out  INSTR_SIZE  instruction to decoder (drives decoder instr).
REQ-013 pc_out  out  `WORD_SIZE  PC of instr_out.
REQ-014 valid_out  out  1  instr_out/pc_out hold a live instruction.

Function
REQ-015 States: FETCH (normal), DROP (discard response of a squashed in-flight request).
REQ-016 icache_addr shall equal internal pc register; bits [1:0] always 0.
REQ-017 icache_req shall be 1 in FETCH and DROP unless (stall & valid_out) in FETCH.
REQ-018 Once icache_req=1 without ready, icache_addr and icache_req shall stay stable until icache_ready=1.
REQ-019 FETCH, icache_ready=1, not blocked, no redirect: instr_out<=icache_data, pc_out<=pc, valid_out<=1, pc<=pc+4 (mod 2^32 wrap).
REQ-020 FETCH, icache_ready=0, not blocked: valid_out<=0 unless stall holds it; pc unchanged.
REQ-021 Blocked (stall=1 & valid_out=1): instr_out, pc_out, valid_out, pc all hold.
REQ-022 stall=1 with valid_out=0 shall not block; fetched instruction is captured.
REQ-023 redirect=1 has priority over stall and icache_ready: valid_out<=0, pc<={redirect_pc[31:2],2'b00}.
REQ-024 redirect=1 while request outstanding (icache_req=1, icache_ready=0): address held per REQ-018 by latching target in pending_pc, go to DROP.
REQ-025 DROP: on icache_ready=1 discard data, pc<=pending_pc, go FETCH; valid_out stays 0.
REQ-026 redirect in DROP: overwrite pending_pc, remain DROP.
REQ-027 Latency: hit to valid_out = 1 cycle; redirect to first new-target valid_out >= 2 cycles.
REQ-028 Fetch throughput: one instruction per cycle on continuous hits without stall.

Reset
REQ-029 reset=1: pc<=RESET_PC, state<=FETCH, valid_out<=0, instr_out<=0, pc_out<=0, pending_pc<=0.
REQ-030 reset mid-miss abandons request; subsequent icache_ready before first new request ignored (state FETCH, new addr=RESET_PC).
REQ-031 icache_req shall be 0 during cycles with reset=1.

Configuration
REQ-032 Macro FETCH_JAL_PREDECODE_EN: when defined, captured word with opcode `OPCODE_JUMP sets pc<=pc+sign-extended J-immediate instead of pc+4.
REQ-033 Without FETCH_JAL_PREDECODE_EN: pc always pc+4 on capture; JAL resolved only by redirect.
REQ-034 Redirect always overrides predecoded target.

Verification
REQ-035 Reset, continuous hits with words 0x003100b3, 0x00108093 -> valid_out 1 cycle after first hit, pc_out 0x0, 0x4, instr_out matching.
REQ-036 stall=1 for 3 cycles with valid_out=1 -> instr_out/pc_out constant, icache_req=0, pc unchanged; resumes at next PC.
REQ-037 Miss: icache_ready low 4 cycles at addr 0x8 -> addr stable, valid_out 0, then capture pc_out=0x8.
REQ-038 redirect to 0x1c during miss at 0x20 -> DROP, returned word discarded, next icache_addr=0x1c, pc_out=0x1c.
REQ-039 Macro defined, word 0xff1ff0ef at pc 0x2c -> next icache_addr=0x1c; macro undefined -> 0x30.
REQ-040 redirect_pc=0x23 with stall=1 -> valid_out 0 next cycle, icache_addr=0x20.
